// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status and baud-divisor registers.
// Optional TX-empty interrupt and IRQEN register are built when UART_TX_IRQ_EN is defined.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic [10:0] mem_d_req_tag_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic        uart_txd_o,
    output logic        irq_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [1:0]    reg_sel;
    logic          req;
    logic          is_wr;
    logic          push_req;
    logic          fire;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          irqen_rd;
    logic [31:0]   rdata;
    logic [15:0]   level_ext;
    logic [7:0]    level_rd;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;

    logic [15:0]   div_q;
    logic [10:0]   resp_tag_q;
    logic [31:0]   data_rd_q;
    logic          ack_q;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;

    // Request decode; only a TXDATA push into a full FIFO (with no pop this cycle) is stalled
    assign reg_sel        = mem_d_addr_i[3:2];
    assign is_wr          = |mem_d_wr_i;
    assign req            = mem_d_rd_i | is_wr;
    assign push_req       = is_wr && (reg_sel == 2'd0) && mem_d_wr_i[0];
    assign mem_d_accept_o = ~(push_req & full & ~pop);
    assign fire           = req & mem_d_accept_o;
    assign push           = fire & push_req;

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign busy  = (state_q != S_IDLE);

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= mem_d_data_wr_i[7:0];
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    // Serializer next state; shreg_q[0] always holds the data bit on the line
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    baud_d  = div_q;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    bit_d   = 3'd0;
                    txd_d   = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = div_q;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr_q];
                        baud_d  = div_q;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divisor register, byte-lane write strobes honoured
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_RESET;
        end else if (fire && is_wr && (reg_sel == 2'd2)) begin
            if (mem_d_wr_i[0]) div_q[7:0]  <= mem_d_data_wr_i[7:0];
            if (mem_d_wr_i[1]) div_q[15:8] <= mem_d_data_wr_i[15:8];
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irqen_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (fire && is_wr && (reg_sel == 2'd3) && mem_d_wr_i[0])
                irqen_q <= mem_d_data_wr_i[0];
            irq_q <= irqen_q & empty & (state_q == S_IDLE);
        end
    end

    assign irq_o    = irq_q;
    assign irqen_rd = irqen_q;
`else
    assign irq_o    = 1'b0;
    assign irqen_rd = 1'b0;
`endif

    // Level saturates in the 8-bit STATUS field when FIFO_DEPTH is 256
    assign level_ext = 16'(level_q);
    assign level_rd  = (level_ext > 16'd255) ? 8'hFF : level_ext[7:0];

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            2'd1:    rdata = {16'd0, level_rd, 5'd0, empty, full, busy};
            2'd2:    rdata = {16'd0, div_q};
            2'd3:    rdata = {31'd0, irqen_rd};
            default: rdata = 32'd0;
        endcase
    end

    // Response channel: one ack the cycle after each accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            resp_tag_q <= '0;
            data_rd_q  <= '0;
        end else begin
            ack_q     <= fire;
            data_rd_q <= (fire && !is_wr) ? rdata : 32'd0;
            if (fire) resp_tag_q <= mem_d_req_tag_i;
        end
    end

    assign mem_d_ack_o      = ack_q;
    assign mem_d_resp_tag_o = resp_tag_q;
    assign mem_d_data_rd_o  = data_rd_q;
    assign mem_d_error_o    = 1'b0;
    assign uart_txd_o       = txd_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_d_addr_i[31:4], mem_d_addr_i[1:0], mem_d_data_wr_i[31:16]};

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: bus transactions plus a txd line decoder
// compared against byte queues kept by the bench. Honours UART_TX_IRQ_EN.
module tb_uart_tx_periph;

    localparam int unsigned DEPTH   = 16;
    localparam int          DIV_RST = 3;
    localparam int          BOUND   = 4000;

    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_ST  = 32'h4;
    localparam logic [31:0] A_DIV = 32'h8;
    localparam logic [31:0] A_IE  = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;
    logic [31:0] mem_d_data_rd_o;
    logic        uart_txd_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    bit   rec = 1'b0;
    logic sq[$];
    logic iq[$];

    uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'(DIV_RST))) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_d_addr_i     (mem_d_addr_i),
        .mem_d_data_wr_i  (mem_d_data_wr_i),
        .mem_d_rd_i       (mem_d_rd_i),
        .mem_d_wr_i       (mem_d_wr_i),
        .mem_d_req_tag_i  (mem_d_req_tag_i),
        .mem_d_accept_o   (mem_d_accept_o),
        .mem_d_ack_o      (mem_d_ack_o),
        .mem_d_error_o    (mem_d_error_o),
        .mem_d_resp_tag_o (mem_d_resp_tag_o),
        .mem_d_data_rd_o  (mem_d_data_rd_o),
        .uart_txd_o       (uart_txd_o),
        .irq_o            (irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec) begin
            sq.push_back(uart_txd_o);
            iq.push_back(irq_o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transaction; holds the request until accepted (bounded), returns the response
    task automatic do_req(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [10:0] tag,
                          output logic ack, output logic err, output logic [10:0] rtag,
                          output logic [31:0] rdata, output int stalls);
        @(posedge clk); #1;
        mem_d_rd_i      = rd;
        mem_d_wr_i      = wr;
        mem_d_addr_i    = addr;
        mem_d_data_wr_i = wdata;
        mem_d_req_tag_i = tag;
        stalls = 0;
        @(negedge clk);
        while (!mem_d_accept_o && stalls < BOUND) begin
            stalls++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        ack   = mem_d_ack_o;
        err   = mem_d_error_o;
        rtag  = mem_d_resp_tag_o;
        rdata = mem_d_data_rd_o;
        mem_d_rd_i = 1'b0;
        mem_d_wr_i = 4'h0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] wdata, output int stalls);
        logic a, e; logic [10:0] t; logic [31:0] d;
        do_req(1'b0, 4'hF, addr, wdata, 11'h0, a, e, t, d, stalls);
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rdata);
        logic a, e; logic [10:0] t; int s;
        do_req(1'b1, 4'h0, addr, 32'h0, 11'h0, a, e, t, rdata, s);
    endtask

    task automatic start_rec();
        sq.delete();
        iq.delete();
        rec = 1'b1;
    endtask

    // Line decoder: every bit must hold for div+1 samples; start=0, stop=1
    function automatic void decode(input int div, output logic [7:0] got[$],
                                   output int bad, output int maxgap);
        int p;
        int bl;
        int last_end;
        logic [9:0] bits;
        got.delete();
        bad = 0; maxgap = 0; p = 0; bl = div + 1; last_end = -1;
        while (p < sq.size()) begin
            if (sq[p] !== 1'b0) begin
                if (sq[p] !== 1'b1) bad++;
                p++;
            end else if (p + 10 * bl > sq.size()) begin
                bad++;
                p = sq.size();
            end else begin
                if (last_end >= 0 && (p - last_end) > maxgap) maxgap = p - last_end;
                for (int b = 0; b < 10; b++) begin
                    bits[b] = sq[p + b * bl];
                    for (int k = 1; k < bl; k++)
                        if (sq[p + b * bl + k] !== bits[b]) bad++;
                end
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad++;
                got.push_back(bits[8:1]);
                p += 10 * bl;
                last_end = p;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_d_accept_o, mem_d_ack_o, mem_d_error_o, uart_txd_o, irq_o} !== 5'b10010) begin
            failures++;
            $display("FAIL reset_ctrl: got acc/ack/err/txd/irq=%b expected 10010",
                     {mem_d_accept_o, mem_d_ack_o, mem_d_error_o, uart_txd_o, irq_o});
        end
        checks++;
        if ({mem_d_resp_tag_o, mem_d_data_rd_o} !== 43'd0) begin
            failures++;
            $display("FAIL reset_resp: got tag=%h data=%h expected 0/0", mem_d_resp_tag_o, mem_d_data_rd_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_status_read();
        logic a, e; logic [10:0] t; logic [31:0] d; int s;
        do_req(1'b1, 4'h0, A_ST, 32'h0, 11'h2A5, a, e, t, d, s);
        checks++;
        if (a !== 1'b1 || e !== 1'b0) begin
            failures++;
            $display("FAIL status_ack: got ack=%b err=%b expected 1/0", a, e);
        end
        checks++;
        if (t !== 11'h2A5) begin
            failures++;
            $display("FAIL status_tag: got %h expected 2a5", t);
        end
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("FAIL status_data: got %h expected 00000004", d);
        end
    endtask

    task automatic test_regs();
        logic [15:0] mdl;
        logic [31:0] v, d;
        logic a, e; logic [10:0] t; int s;
        mdl = 16'(DIV_RST);
        rd_reg(A_DIV, d);
        checks++;
        if (d !== {16'd0, mdl}) begin
            failures++;
            $display("FAIL div_reset: got %h expected %h", d, mdl);
        end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            case (i)
                0: begin do_req(1'b0, 4'hF, A_DIV, v, 11'(i), a, e, t, d, s); mdl = v[15:0]; end
                1: begin do_req(1'b0, 4'h2, A_DIV, v, 11'(i), a, e, t, d, s); mdl[15:8] = v[15:8]; end
                2: begin do_req(1'b0, 4'hC, A_DIV, v, 11'(i), a, e, t, d, s); end
                default: begin do_req(1'b1, 4'h1, A_DIV, v, 11'(i), a, e, t, d, s); mdl[7:0] = v[7:0]; end
            endcase
            checks++;
            if (a !== 1'b1 || t !== 11'(i) || d !== 32'h0) begin
                failures++;
                $display("FAIL div_wr_resp%0d: got ack=%b tag=%h data=%h expected 1/%h/0", i, a, t, d, 11'(i));
            end
            rd_reg(A_DIV, d);
            checks++;
            if (d !== {16'd0, mdl}) begin
                failures++;
                $display("FAIL div_rw%0d: got %h expected %h", i, d, mdl);
            end
        end
        wr_reg(A_ST, 32'hFFFF_FFFF, s);
        rd_reg(A_ST, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("FAIL status_ro: got %h expected 00000004", d);
        end
        rd_reg(A_TX, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL txdata_read: got %h expected 0", d);
        end
    endtask

    task automatic test_frame_55();
        logic [7:0] got[$];
        logic [31:0] d;
        int bad, gap, s;
        wr_reg(A_DIV, 32'd3, s);
        start_rec();
        wr_reg(A_TX, 32'h55, s);
        repeat (10) @(posedge clk);
        rd_reg(A_ST, d);
        checks++;
        if (d !== 32'h5) begin
            failures++;
            $display("FAIL frame55_busy: got status %h expected 00000005", d);
        end
        repeat (50) @(posedge clk);
        rec = 1'b0;
        decode(3, got, bad, gap);
        checks++;
        if (bad != 0 || got.size() != 1 || got[0] !== 8'h55) begin
            failures++;
            $display("FAIL frame55: got %0d bytes first=%h bad=%0d expected 1 byte 55 bad=0",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx, bad);
        end
    endtask

    task automatic test_random_bytes();
        logic [7:0] exp[$];
        logic [7:0] got[$];
        int div, n, bad, gap, s, mism;
        for (int it = 0; it < 3; it++) begin
            div = $urandom_range(0, 4);
            n   = $urandom_range(2, 6);
            exp.delete();
            wr_reg(A_DIV, 32'(div), s);
            start_rec();
            for (int k = 0; k < n; k++) begin
                exp.push_back(8'($urandom));
                wr_reg(A_TX, {24'd0, exp[k]}, s);
            end
            repeat (n * 10 * (div + 1) + 40) @(posedge clk);
            rec = 1'b0;
            decode(div, got, bad, gap);
            mism = 0;
            for (int k = 0; k < n && k < got.size(); k++) if (got[k] !== exp[k]) mism++;
            checks++;
            if (bad != 0 || got.size() != n || mism != 0) begin
                failures++;
                $display("FAIL random_bytes%0d: got %0d bytes mism=%0d bad=%0d expected %0d bytes div=%0d",
                         it, got.size(), mism, bad, n, div);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        int bad, gap, s;
        wr_reg(A_DIV, 32'd0, s);
        start_rec();
        wr_reg(A_TX, 32'hA0, s);
        wr_reg(A_TX, 32'hA1, s);
        repeat (40) @(posedge clk);
        rec = 1'b0;
        decode(0, got, bad, gap);
        checks++;
        if (bad != 0 || got.size() != 2 || got[0] !== 8'hA0 || got[1] !== 8'hA1) begin
            failures++;
            $display("FAIL b2b_bytes: got %0d bytes bad=%0d expected A0,A1", got.size(), bad);
        end
        checks++;
        if (gap != 0) begin
            failures++;
            $display("FAIL b2b_gap: got idle gap %0d expected 0", gap);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp[$];
        logic [7:0] got[$];
        logic [31:0] d;
        int bad, gap, s, tot, mism;
        wr_reg(A_DIV, 32'd15, s);
        exp.delete();
        start_rec();
        tot = 0;
        // first byte goes straight to the serializer, next DEPTH bytes fill the FIFO
        for (int k = 0; k < DEPTH + 1; k++) begin
            exp.push_back(8'($urandom));
            wr_reg(A_TX, {24'd0, exp[k]}, s);
            tot += s;
        end
        checks++;
        if (tot != 0) begin
            failures++;
            $display("FAIL fill_stalls: got %0d stall cycles expected 0", tot);
        end
        rd_reg(A_ST, d);
        checks++;
        if (d !== {16'd0, 8'(DEPTH), 8'h03}) begin
            failures++;
            $display("FAIL full_status: got %h expected %h", d, {16'd0, 8'(DEPTH), 8'h03});
        end
        exp.push_back(8'($urandom));
        wr_reg(A_TX, {24'd0, exp[DEPTH + 1]}, s);
        checks++;
        if (s == 0 || s >= BOUND) begin
            failures++;
            $display("FAIL full_stall: got %0d stall cycles expected between 1 and %0d", s, BOUND - 1);
        end
        repeat ((DEPTH + 2) * 160 + 60) @(posedge clk);
        rec = 1'b0;
        decode(15, got, bad, gap);
        mism = 0;
        for (int k = 0; k < exp.size() && k < got.size(); k++) if (got[k] !== exp[k]) mism++;
        checks++;
        if (bad != 0 || got.size() != exp.size() || mism != 0) begin
            failures++;
            $display("FAIL full_order: got %0d bytes mism=%0d bad=%0d expected %0d", got.size(), mism, bad, exp.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got[$];
        logic [31:0] d;
        int bad, gap, s;
        wr_reg(A_DIV, 32'd3, s);
        wr_reg(A_TX, 32'h00, s);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (uart_txd_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_txd: got %b expected 1", uart_txd_o);
        end
        start_rec();
        rd_reg(A_ST, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("FAIL midreset_status: got %h expected 00000004", d);
        end
        rd_reg(A_DIV, d);
        checks++;
        if (d !== 32'(DIV_RST)) begin
            failures++;
            $display("FAIL midreset_div: got %h expected %h", d, 32'(DIV_RST));
        end
        repeat (60) @(posedge clk);
        rec = 1'b0;
        decode(DIV_RST, got, bad, gap);
        checks++;
        if (bad != 0 || got.size() != 0) begin
            failures++;
            $display("FAIL midreset_residual: got %0d bytes bad=%0d expected idle line", got.size(), bad);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int s, st, nz;
        wr_reg(A_IE, 32'h1, s);
        rd_reg(A_IE, d);
        repeat (3) @(posedge clk);
        start_rec();
        wr_reg(A_TX, 32'h3C, s);
        repeat (80) @(posedge clk);
        rec = 1'b0;
        st = -1;
        for (int i = 0; i < sq.size(); i++) if (st < 0 && sq[i] === 1'b0) st = i;
`ifdef UART_TX_IRQ_EN
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL irqen_read: got %h expected 1", d);
        end
        checks++;
        if (st < 1 || st + 41 >= iq.size() || iq[st - 1] !== 1'b1) begin
            failures++;
            $display("FAIL irq_idle: start index %0d, irq before frame not 1", st);
        end else begin
            nz = 0;
            for (int i = st; i <= st + 40; i++) if (iq[i] !== 1'b0) nz++;
            checks++;
            if (nz != 0) begin
                failures++;
                $display("FAIL irq_busy: got %0d high samples during frame expected 0", nz);
            end
            checks++;
            if (iq[st + 41] !== 1'b1) begin
                failures++;
                $display("FAIL irq_rise: got %b one cycle after stop expected 1", iq[st + 41]);
            end
        end
`else
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL irqen_read: got %h expected 0", d);
        end
        nz = 0;
        for (int i = 0; i < iq.size(); i++) if (iq[i] !== 1'b0) nz++;
        checks++;
        if (nz != 0 || st < 0) begin
            failures++;
            $display("FAIL irq_tied: got %0d high samples, frame start %0d expected 0 and a frame", nz, st);
        end
`endif
    endtask

    initial begin
        rst             = 1'b1;
        mem_d_addr_i    = '0;
        mem_d_data_wr_i = '0;
        mem_d_rd_i      = 1'b0;
        mem_d_wr_i      = 4'h0;
        mem_d_req_tag_i = '0;
        test_reset();
        test_status_read();
        test_regs();
        test_frame_55();
        test_random_bytes();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
